// File: rtl/yc_pkg.sv
// Shared definitions for the ycell configuration store: code width and the
// eight 3-bit cell codes.
package yc_pkg;

  localparam int unsigned CFG_W = 3;

  localparam logic [CFG_W-1:0] CODE_SPACE = 3'b000;
  localparam logic [CFG_W-1:0] CODE_PLUS  = 3'b001;
  localparam logic [CFG_W-1:0] CODE_HWIRE = 3'b010;
  localparam logic [CFG_W-1:0] CODE_VWIRE = 3'b011;
  localparam logic [CFG_W-1:0] CODE_ONE   = 3'b100;
  localparam logic [CFG_W-1:0] CODE_ZERO  = 3'b101;
  localparam logic [CFG_W-1:0] CODE_Y     = 3'b110;
  localparam logic [CFG_W-1:0] CODE_N     = 3'b111;

endpackage : yc_pkg

// File: rtl/yc_cfg_decode.sv
// Combinational decode of a ycell code into its control lines.
// Ports:
//   cfg                                  - cell code
//   empty                                - code is space
//   hblock/hbypass/hmatch0/hmatch1       - horizontal controls (one-hot or zero)
//   vblock/vbypass/vmatch0/vmatch1       - vertical controls (one-hot or zero)
module yc_cfg_decode
  import yc_pkg::*;
(
  input  logic [CFG_W-1:0] cfg,
  output logic             empty,
  output logic             hblock,
  output logic             hbypass,
  output logic             hmatch0,
  output logic             hmatch1,
  output logic             vblock,
  output logic             vbypass,
  output logic             vmatch0,
  output logic             vmatch1
);

  // Code to control-line table; unknown codes leave everything deasserted.
  always_comb begin
    empty   = 1'b0;
    hblock  = 1'b0;
    hbypass = 1'b0;
    hmatch0 = 1'b0;
    hmatch1 = 1'b0;
    vblock  = 1'b0;
    vbypass = 1'b0;
    vmatch0 = 1'b0;
    vmatch1 = 1'b0;
    case (cfg)
      CODE_SPACE: begin
        empty  = 1'b1;
        hblock = 1'b1;
        vblock = 1'b1;
      end
      CODE_PLUS: begin
        hbypass = 1'b1;
        vbypass = 1'b1;
      end
      CODE_HWIRE: begin
        hbypass = 1'b1;
        vblock  = 1'b1;
      end
      CODE_VWIRE: begin
        hblock  = 1'b1;
        vbypass = 1'b1;
      end
      CODE_ONE: begin
        hmatch1 = 1'b1;
        vmatch1 = 1'b1;
      end
      CODE_ZERO: begin
        hmatch0 = 1'b1;
        vmatch0 = 1'b1;
      end
      CODE_Y: begin
        hmatch1 = 1'b1;
        vmatch0 = 1'b1;
      end
      CODE_N: begin
        hmatch0 = 1'b1;
        vmatch1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : yc_cfg_decode

// File: rtl/yc_config.sv
// Per-cell configuration store for a Morphle Logic ycell. A 3-bit code is
// shifted in msb first on confclk and decoded into the cell control lines.
// Cells chain cbitout->cbitin, so each cell delays the stream by 3 clocks.
// Ports:
//   confclk  - configuration clock (rising edge)
//   reset    - synchronous active-high clear of the code register
//   cbitin   - serial code bit in
//   cbitout  - serial code bit out (current code msb)
//   empty, h*/v* - combinational decode of the current code
module yc_config
  import yc_pkg::*;
(
  input  logic confclk,
  input  logic reset,
  input  logic cbitin,
  output logic cbitout,
  output logic empty,
  output logic hblock,
  output logic hbypass,
  output logic hmatch0,
  output logic hmatch1,
  output logic vblock,
  output logic vbypass,
  output logic vmatch0,
  output logic vmatch1
);

  logic [CFG_W-1:0] cfg;

  // Code shift register; reset wins over shifting.
  always_ff @(posedge confclk) begin
    if (reset) begin
      cfg <= '0;
    end else begin
      cfg <= {cfg[CFG_W-2:0], cbitin};
    end
  end

  assign cbitout = cfg[CFG_W-1];

  yc_cfg_decode u_decode (
    .cfg     (cfg),
    .empty   (empty),
    .hblock  (hblock),
    .hbypass (hbypass),
    .hmatch0 (hmatch0),
    .hmatch1 (hmatch1),
    .vblock  (vblock),
    .vbypass (vbypass),
    .vmatch0 (vmatch0),
    .vmatch1 (vmatch1)
  );

endmodule : yc_config

// File: tb/tb_yc_config.sv
// Directed bench: two chained yc_config cells checked against a hand-written
// decode table.
module tb_yc_config;

  logic confclk;
  logic reset;
  logic cbitin;

  logic c1_cbitout, c1_empty, c1_hblock, c1_hbypass, c1_hmatch0, c1_hmatch1;
  logic c1_vblock, c1_vbypass, c1_vmatch0, c1_vmatch1;
  logic c2_cbitout, c2_empty, c2_hblock, c2_hbypass, c2_hmatch0, c2_hmatch1;
  logic c2_vblock, c2_vbypass, c2_vmatch0, c2_vmatch1;

  int total = 0;
  int bad   = 0;

  yc_config cell1 (
    .confclk (confclk),
    .reset   (reset),
    .cbitin  (cbitin),
    .cbitout (c1_cbitout),
    .empty   (c1_empty),
    .hblock  (c1_hblock),
    .hbypass (c1_hbypass),
    .hmatch0 (c1_hmatch0),
    .hmatch1 (c1_hmatch1),
    .vblock  (c1_vblock),
    .vbypass (c1_vbypass),
    .vmatch0 (c1_vmatch0),
    .vmatch1 (c1_vmatch1)
  );

  yc_config cell2 (
    .confclk (confclk),
    .reset   (reset),
    .cbitin  (c1_cbitout),
    .cbitout (c2_cbitout),
    .empty   (c2_empty),
    .hblock  (c2_hblock),
    .hbypass (c2_hbypass),
    .hmatch0 (c2_hmatch0),
    .hmatch1 (c2_hmatch1),
    .vblock  (c2_vblock),
    .vbypass (c2_vbypass),
    .vmatch0 (c2_vmatch0),
    .vmatch1 (c2_vmatch1)
  );

  initial confclk = 1'b0;
  always #5 confclk = ~confclk;

  // Observed vector: {cbitout, empty, hblock, hbypass, hmatch0, hmatch1,
  //                   vblock, vbypass, vmatch0, vmatch1}
  logic [9:0] obs1, obs2;
  assign obs1 = {c1_cbitout, c1_empty, c1_hblock, c1_hbypass, c1_hmatch0, c1_hmatch1,
                 c1_vblock, c1_vbypass, c1_vmatch0, c1_vmatch1};
  assign obs2 = {c2_cbitout, c2_empty, c2_hblock, c2_hbypass, c2_hmatch0, c2_hmatch1,
                 c2_vblock, c2_vbypass, c2_vmatch0, c2_vmatch1};

  // Hand-written expected outputs per code.
  function automatic logic [9:0] exp_of(input logic [2:0] code);
    case (code)
      3'b000:  return 10'b0_1_1000_1000;
      3'b001:  return 10'b0_0_0100_0100;
      3'b010:  return 10'b0_0_0100_1000;
      3'b011:  return 10'b0_0_1000_0100;
      3'b100:  return 10'b1_0_0001_0001;
      3'b101:  return 10'b1_0_0010_0010;
      3'b110:  return 10'b1_0_0001_0010;
      default: return 10'b1_0_0010_0001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one bit, take one confclk edge, sample 1 time unit later.
  task automatic shift_bit(input logic b);
    cbitin = b;
    @(posedge confclk);
    #1;
  endtask

  task automatic shift_code(input logic [2:0] code);
    shift_bit(code[2]);
    shift_bit(code[1]);
    shift_bit(code[0]);
  endtask

  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    reset  = 1'b1;
    cbitin = 1'b1;

    // Reset: one edge clears both cells even with cbitin=1.
    @(posedge confclk);
    #1;
    check("reset c1", obs1, 10'b0_1_1000_1000);
    check("reset c2", obs2, 10'b0_1_1000_1000);
    reset = 1'b0;

    // Decode sweep through the chain; cell2 trails cell1 by one code.
    prev = 3'b000;
    for (int c = 0; c < 8; c++) begin
      cur = 3'(c);
      shift_code(cur);
      check($sformatf("sweep c1 code%0d", c), obs1, exp_of(cur));
      check($sformatf("sweep c2 code%0d", c), obs2, exp_of(prev));
      check_bit($sformatf("inv h onehot0 code%0d", c),
                $onehot0({c1_hblock, c1_hbypass, c1_hmatch0, c1_hmatch1}), 1'b1);
      check_bit($sformatf("inv v onehot0 code%0d", c),
                $onehot0({c1_vblock, c1_vbypass, c1_vmatch0, c1_vmatch1}), 1'b1);
      check_bit($sformatf("inv empty code%0d", c), c1_empty, (cur == 3'b000));
      prev = cur;
    end

    // Mid-shift: load N, then 1 (still N), then 0 gives Y with cbitout=1.
    shift_code(3'b111);
    check("midshift load N c1", obs1, 10'b1_0_0010_0001);
    shift_bit(1'b1);
    check("midshift +1 c1", obs1, 10'b1_0_0010_0001);
    shift_bit(1'b0);
    check("midshift +2 c1 Y", obs1, 10'b1_0_0001_0010);
    check("midshift c2 N", obs2, 10'b1_0_0010_0001);

    // Reset mid-stream: load '0', one pending bit, then reset clears both.
    shift_code(3'b101);
    check("load 0 c1", obs1, 10'b1_0_0010_0010);
    check("load 0 c2 Y", obs2, 10'b1_0_0001_0010);
    shift_bit(1'b1);
    check("pending bit c1 is |", obs1, 10'b0_0_1000_0100);
    reset = 1'b1;
    shift_bit(1'b1);
    check("midreset c1", obs1, 10'b0_1_1000_1000);
    check("midreset c2", obs2, 10'b0_1_1000_1000);
    reset = 1'b0;

    // Shifting resumes from 000: one '1' bit gives '+' in cell1 only.
    shift_bit(1'b1);
    check("resume c1 plus", obs1, 10'b0_0_0100_0100);
    check("resume c2 space", obs2, 10'b0_1_1000_1000);

    // Shift 0,1,0: cell1 becomes '-', cell2 picks up the earlier '+'.
    shift_code(3'b010);
    check("chain c1 hwire", obs1, 10'b0_0_0100_1000);
    check("chain c2 plus", obs2, 10'b0_0_0100_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_yc_config

// File: doc/yc_config.md
Name: yc_config

Overview:
- Per-cell configuration store for a Morphle Logic ycell.
- Holds a 3-bit cell code in a serial shift register clocked by confclk, and decodes it into the empty flag and horizontal/vertical control lines.
- Cells are chained cbitout→cbitin, so one serial stream configures a whole row or array.
- After three confclk edges, the downstream cell holds exactly the code this cell held before those edges.

Parameters:
- CFG_W, 3, width of the cell code (fixed at 3; any other value is unsupported).

Ports:
- confclk  input  1  configuration clock; all state updates on its rising edge
- reset    input  1  synchronous, active-high; clears the code register
- cbitin   input  1  serial configuration bit in; the code is sent msb first
- cbitout  input→output  1  output: serial bit out to the next cell; equals current code msb
- empty    output 1  cell code is space
- hblock   output 1  horizontal path blocked
- hbypass  output 1  horizontal signal passes straight through
- hmatch0  output 1  horizontal side matches value 0
- hmatch1  output 1  horizontal side matches value 1
- vblock   output 1  vertical path blocked
- vbypass  output 1  vertical signal passes straight through
- vmatch0  output 1  vertical side matches value 0
- vmatch1  output 1  vertical side matches value 1

Behaviour:
- State is cfg[2:0].
- Rising edge of confclk:
  - reset=1: cfg←000 (reset has priority over shifting).
  - otherwise: cfg←{cfg[1:0],cbitin}.
- cbitout = cfg[2], combinational from the register. The chain therefore delays the stream by exactly 3 clocks per cell.
- Reset values:
  - empty=1, hblock=1, vblock=1, cbitout=0.
  - All other outputs 0.
- All decode outputs are purely combinational from cfg, with no extra register.
- While a new code is being shifted in, outputs follow the partially shifted contents. Consumers must treat outputs as valid only after a multiple of 3 clocks.
- Code decode (every output not listed is 0):
  - 000 space: empty, hblock, vblock
  - 001 '+': hbypass, vbypass
  - 010 '-': hbypass, vblock
  - 011 '|': hblock, vbypass
  - 100 '1': hmatch1, vmatch1
  - 101 '0': hmatch0, vmatch0
  - 110 'Y': hmatch1, vmatch0
  - 111 'N': hmatch0, vmatch1
- Invariants for every code:
  - At most one of {hblock, hbypass, hmatch0, hmatch1} is 1; likewise for the v group.
  - empty=1 only for 000.
- Reset asserted mid-stream: the register clears on that edge and shifting resumes from 000 on the next edge after reset deasserts. There is no bit-phase counter; framing is the sender's responsibility.
- cbitin is sampled only at the rising edge. X on cbitin propagates into cfg; no masking is applied.

Decomposition:
- Shared package yc_pkg holds:
  - localparams for the 8 codes: CODE_SPACE=000, CODE_PLUS=001, CODE_HWIRE=010, CODE_VWIRE=011, CODE_ONE=100, CODE_ZERO=101, CODE_Y=110, CODE_N=111.
  - CFG_W.
- A single combinational sub-module, yc_cfg_decode (cfg→10 control outputs), is natural. The ycell reuses it for readback checks; the shift register stays in yc_config.

Test Plan:
- Reset: reset=1 for one confclk edge → cfg=000; empty=1, hblock=1, vblock=1, all other outputs 0, cbitout=0.
- Single-cell decode sweep: shift 000,001,…,111 msb first, 3 clocks each. After each triplet, check outputs exactly per the decode list (e.g. after 010: hbypass=1, vblock=1, rest 0; after 110: hmatch1=1, vmatch0=1).
- Two-cell chain (cell2.cbitin=cell1.cbitout), same 24-bit stream. After each triplet, cell2 decodes the previous code of cell1 (after '-' is loaded, cell1 shows '-' and cell2 shows '+'). After the first triplet, cell2 shows space.
- Mid-shift observability: load 111, then shift in 1,0 → after 2 clocks cfg=110; Y decode visible; cbitout=1.
- Reset mid-stream: load 101, shift in one bit, assert reset on the next edge → both chained cells unaffected by the pending bit; cell1 cfg=000.
- Invariant check: for every code, assert the h-group and v-group are one-hot-or-zero and empty ⇔ cfg==000.
